// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, instruction field positions, opcode
// encodings, FOA stage state encoding and the operand-A usage decode.
package cpu_pkg;

    localparam int ADDR_WIDTH      = 10;
    localparam int DATA_WIDTH      = 32;
    localparam int DMEM_ADDR_WIDTH = 14;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int A_MSB   = 27;
    localparam int A_LSB   = 14;
    localparam int B_MSB   = 13;
    localparam int B_LSB   = 0;

    localparam logic [3:0] OP_NAND = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_ADDF = 4'b0010;
    localparam logic [3:0] OP_ADDi = 4'b0011;
    localparam logic [3:0] OP_LT   = 4'b0100;
    localparam logic [3:0] OP_LTF  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRLi = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_MULF = 4'b1001;
    localparam logic [3:0] OP_CP   = 4'b1010;
    localparam logic [3:0] OP_CPi  = 4'b1011;
    localparam logic [3:0] OP_CPI  = 4'b1100;
    localparam logic [3:0] OP_CPIr = 4'b1101;
    localparam logic [3:0] OP_BZ   = 4'b1110;
    localparam logic [3:0] OP_JMP  = 4'b1111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_WAIT  = 2'b01,
        ST_FULL  = 2'b10
    } foa_state_t;

    // Copy instructions take their source from B (or an immediate), so A is never read.
    function automatic logic uses_operand_a(input logic [3:0] opcode);
        case (opcode)
            OP_CP, OP_CPi, OP_CPI: return 1'b0;
            default:               return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/foa_bypass_unit.sv
// Writeback-to-operand-A bypass: latches a writeback hit on the accepted A address
// and flags writebacks that hit the A address of the held instruction.
module foa_bypass_unit #(
    parameter int DATA_WIDTH      = 32,
    parameter int DMEM_ADDR_WIDTH = 14
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       capture,
    input  logic [DMEM_ADDR_WIDTH-1:0] capture_addr,
    input  logic                       wb_valid,
    input  logic [DMEM_ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]      wb_data,
    input  logic [DATA_WIDTH-1:0]      mem_rdata,
    input  logic [DMEM_ADDR_WIDTH-1:0] held_addr,
    output logic [DATA_WIDTH-1:0]      wait_data,
    output logic                       held_hit
);

    logic                  hit_q;
    logic [DATA_WIDTH-1:0] data_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q  <= 1'b0;
            data_q <= '0;
        end else if (capture) begin
            hit_q  <= wb_valid && (wb_addr == capture_addr);
            data_q <= wb_data;
        end
    end

    assign wait_data = hit_q ? data_q : mem_rdata;
    assign held_hit  = wb_valid && (wb_addr == held_addr);

endmodule

// File: rtl/fetch_operand_a.sv
// FOA pipeline stage: accepts FI slots, reads operand A from data memory and hands
// {pc, opcode, A, B, opA} to FOB. Define FOA_WB_BYPASS_EN to enable writeback bypass.
module fetch_operand_a #(
    parameter int ADDR_WIDTH      = cpu_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH      = cpu_pkg::DATA_WIDTH,
    parameter int DMEM_ADDR_WIDTH = cpu_pkg::DMEM_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       instr_valid_in,
    input  logic [ADDR_WIDTH-1:0]      instr_pc_in,
    input  logic [DATA_WIDTH-1:0]      instr_data_in,
    input  logic                       flush,
    input  logic                       stall_in,
    output logic                       stall_out,
    output logic                       mem_a_rd_en,
    output logic [DMEM_ADDR_WIDTH-1:0] mem_a_addr,
    input  logic [DATA_WIDTH-1:0]      mem_a_rdata,
    input  logic                       wb_valid,
    input  logic [DMEM_ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]      wb_data,
    output logic                       valid_out,
    output logic [ADDR_WIDTH-1:0]      pc_out,
    output logic [3:0]                 opcode_out,
    output logic [DMEM_ADDR_WIDTH-1:0] field_a_out,
    output logic [DMEM_ADDR_WIDTH-1:0] field_b_out,
    output logic [DATA_WIDTH-1:0]      operand_a_out
);

    import cpu_pkg::*;

    foa_state_t            state;
    logic                  uses_a_q;
    logic [DATA_WIDTH-1:0] opa_q;
    logic                  accept;
    logic                  uses_a_in;
    logic [3:0]            opcode_in;
    logic [DATA_WIDTH-1:0] raw_opa;
    logic [DATA_WIDTH-1:0] wait_opa;
    logic [DATA_WIDTH-1:0] full_opa_next;

    assign opcode_in   = instr_data_in[OPC_MSB:OPC_LSB];
    assign uses_a_in   = uses_operand_a(opcode_in);
    assign stall_out   = (state != ST_EMPTY) && stall_in;
    assign accept      = instr_valid_in && !stall_out && !flush && !rst;
    assign mem_a_rd_en = accept && uses_a_in;
    assign mem_a_addr  = instr_data_in[A_MSB:A_LSB];
    assign valid_out   = (state != ST_EMPTY);

`ifdef FOA_WB_BYPASS_EN
    logic held_hit;

    foa_bypass_unit #(
        .DATA_WIDTH      (DATA_WIDTH),
        .DMEM_ADDR_WIDTH (DMEM_ADDR_WIDTH)
    ) u_bypass (
        .clk          (clk),
        .rst          (rst),
        .capture      (accept),
        .capture_addr (mem_a_addr),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .mem_rdata    (mem_a_rdata),
        .held_addr    (field_a_out),
        .wait_data    (raw_opa),
        .held_hit     (held_hit)
    );

    assign full_opa_next = (held_hit && uses_a_q) ? wb_data : opa_q;
`else
    logic unused_wb;

    assign unused_wb     = ^{wb_valid, wb_addr, wb_data};
    assign raw_opa       = mem_a_rdata;
    assign full_opa_next = opa_q;
`endif

    // Memory data is only meaningful in the cycle right after the read was issued.
    assign wait_opa      = uses_a_q ? raw_opa : '0;
    assign operand_a_out = (state == ST_WAIT) ? wait_opa : opa_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_EMPTY;
            pc_out      <= '0;
            opcode_out  <= '0;
            field_a_out <= '0;
            field_b_out <= '0;
            uses_a_q    <= 1'b0;
            opa_q       <= '0;
        end else begin
            if (accept) begin
                pc_out      <= instr_pc_in;
                opcode_out  <= opcode_in;
                field_a_out <= instr_data_in[A_MSB:A_LSB];
                field_b_out <= instr_data_in[B_MSB:B_LSB];
                uses_a_q    <= uses_a_in;
            end

            if (flush) begin
                state <= ST_EMPTY;
            end else begin
                case (state)
                    ST_EMPTY: begin
                        if (accept) state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (stall_in) begin
                            opa_q <= wait_opa;
                            state <= ST_FULL;
                        end else begin
                            state <= accept ? ST_WAIT : ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (stall_in) begin
                            opa_q <= full_opa_next;
                        end else begin
                            state <= accept ? ST_WAIT : ST_EMPTY;
                        end
                    end
                    default: state <= ST_EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_operand_a.sv
// Self-checking bench for fetch_operand_a: directed scenarios followed by random traffic,
// compared each cycle against a slot-level reference model (honours FOA_WB_BYPASS_EN).
module tb_fetch_operand_a;

    import cpu_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MW = 14;
`ifdef FOA_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_valid_in;
    logic [AW-1:0] instr_pc_in;
    logic [DW-1:0] instr_data_in;
    logic          flush;
    logic          stall_in;
    logic          stall_out;
    logic          mem_a_rd_en;
    logic [MW-1:0] mem_a_addr;
    logic [DW-1:0] mem_a_rdata;
    logic          wb_valid;
    logic [MW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          valid_out;
    logic [AW-1:0] pc_out;
    logic [3:0]    opcode_out;
    logic [MW-1:0] field_a_out;
    logic [MW-1:0] field_b_out;
    logic [DW-1:0] operand_a_out;

    always #5 clk = ~clk;

    fetch_operand_a dut (
        .clk            (clk),
        .rst            (rst),
        .instr_valid_in (instr_valid_in),
        .instr_pc_in    (instr_pc_in),
        .instr_data_in  (instr_data_in),
        .flush          (flush),
        .stall_in       (stall_in),
        .stall_out      (stall_out),
        .mem_a_rd_en    (mem_a_rd_en),
        .mem_a_addr     (mem_a_addr),
        .mem_a_rdata    (mem_a_rdata),
        .wb_valid       (wb_valid),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .valid_out      (valid_out),
        .pc_out         (pc_out),
        .opcode_out     (opcode_out),
        .field_a_out    (field_a_out),
        .field_b_out    (field_b_out),
        .operand_a_out  (operand_a_out)
    );

    // Data memory with 1-cycle read latency; read data is junk whenever no read was issued.
    logic [DW-1:0] dmem [0:(1<<MW)-1];
    always @(posedge clk) mem_a_rdata <= mem_a_rd_en ? dmem[mem_a_addr] : $urandom();

    int checks = 0;
    int errors = 0;

    // Reference model: one stage slot holding the instruction and the operand it must deliver.
    bit            m_v = 1'b0;
    int            m_age;
    logic [AW-1:0] m_pc;
    logic [3:0]    m_opc;
    logic [MW-1:0] m_a;
    logic [MW-1:0] m_b;
    logic [DW-1:0] m_opa;

    function automatic bit reads_a(input logic [3:0] opc);
        return !(opc == OP_CP || opc == OP_CPi || opc == OP_CPI);
    endfunction

    function automatic logic [DW-1:0] enc(input logic [3:0] opc, input logic [MW-1:0] a,
                                          input logic [MW-1:0] b);
        return {opc, a, b};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input logic [AW-1:0] pc, input logic [DW-1:0] instr,
                        input bit fl, input bit st, input bit wv, input logic [MW-1:0] wa,
                        input logic [DW-1:0] wd);
        bit            exp_stall;
        bit            acc;
        bit            use_a;
        logic [MW-1:0] a_in;
        @(negedge clk);
        instr_valid_in = v;
        instr_pc_in    = pc;
        instr_data_in  = instr;
        flush          = fl;
        stall_in       = st;
        wb_valid       = wv;
        wb_addr        = wa;
        wb_data        = wd;
        #1;
        a_in      = instr[27:14];
        exp_stall = m_v && st;
        acc       = v && !exp_stall && !fl;
        use_a     = reads_a(instr[31:28]);
        check("stall_out", stall_out, exp_stall);
        check("mem_a_rd_en", mem_a_rd_en, acc && use_a);
        if (acc) check("mem_a_addr", mem_a_addr, a_in);
        check("valid_out", valid_out, m_v);
        if (m_v) begin
            check("pc_out", pc_out, m_pc);
            check("opcode_out", opcode_out, m_opc);
            check("field_a_out", field_a_out, m_a);
            check("field_b_out", field_b_out, m_b);
            check("operand_a_out", operand_a_out, m_opa);
        end
        if (fl) begin
            m_v = 1'b0;
        end else if (m_v && st) begin
            if (BYP && m_age > 0 && reads_a(m_opc) && wv && wa == m_a) m_opa = wd;
            m_age++;
        end else if (acc) begin
            m_v   = 1'b1;
            m_age = 0;
            m_pc  = pc;
            m_opc = instr[31:28];
            m_a   = a_in;
            m_b   = instr[13:0];
            if (!use_a)                     m_opa = '0;
            else if (BYP && wv && wa == a_in) m_opa = wd;
            else                            m_opa = dmem[a_in];
        end else begin
            m_v = 1'b0;
        end
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        instr_valid_in = 1'b1;
        instr_data_in  = enc(OP_ADD, 14'd5, 14'd0);
        flush          = 1'b0;
        stall_in       = 1'b0;
        wb_valid       = 1'b0;
        #1;
        check("rst_rd_en", mem_a_rd_en, 1'b0);
        @(negedge clk);
        rst            = 1'b0;
        instr_valid_in = 1'b0;
        stall_in       = 1'b1;
        m_v            = 1'b0;
        #1;
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_stall_out", stall_out, 1'b0);
        check("rst_pc_out", pc_out, '0);
        check("rst_opcode_out", opcode_out, '0);
        check("rst_field_a_out", field_a_out, '0);
        check("rst_field_b_out", field_b_out, '0);
        check("rst_operand_a_out", operand_a_out, '0);
        check("rst_rd_en_idle", mem_a_rd_en, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < (1 << MW); i++) dmem[i] = $urandom();
        dmem[5] = 32'h0000_1234;
        dmem[7] = 32'h0000_002A;
        instr_pc_in = '0;
        wb_addr     = '0;
        wb_data     = '0;

        do_reset();

        // ADD A=5 at PC 3, then back-to-back ADDs at PC 0..3
        step(1'b1, 10'd3, enc(OP_ADD, 14'd5, 14'd11), 1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++)
            step(1'b1, AW'(i), enc(OP_ADD, MW'(i + 4), MW'(i)), 1'b0, 1'b0, 1'b0, '0, '0);
        idle();

        // Stall held three cycles while the operand is arriving
        step(1'b1, 10'd9, enc(OP_ADD, 14'd5, 14'd1), 1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 10'd10, enc(OP_ADD, 14'd6, 14'd2), 1'b0, 1'b1, 1'b0, '0, '0);
        idle();

        // Copy-immediate has no operand A; CPIr reads the pointer
        step(1'b1, 10'd20, enc(OP_CPi, 14'd5, 14'd3), 1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 10'd21, enc(OP_CPIr, 14'd7, 14'd4), 1'b0, 1'b0, 1'b0, '0, '0);
        idle();

        // Flush while FULL and stalled, with a valid input offered in the same cycle
        step(1'b1, 10'd30, enc(OP_ADD, 14'd5, 14'd0), 1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 10'd31, enc(OP_ADD, 14'd6, 14'd0), 1'b0, 1'b1, 1'b0, '0, '0);
        step(1'b1, 10'd32, enc(OP_ADD, 14'd7, 14'd0), 1'b1, 1'b1, 1'b0, '0, '0);
        idle();

        // Writeback to A in the accept cycle, then a writeback hitting a FULL slot
        step(1'b1, 10'd40, enc(OP_ADD, 14'd5, 14'd0), 1'b0, 1'b0, 1'b1, 14'd5, 32'h0000_BEEF);
        idle();
        step(1'b1, 10'd41, enc(OP_ADD, 14'd6, 14'd0), 1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 14'd6, 32'h0000_CAFE);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        idle();

        // Random traffic on a small address window so writebacks hit often; reset mid-stream
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            step($urandom_range(0, 3) != 0, AW'($urandom()),
                 enc(4'($urandom()), MW'($urandom_range(0, 7)), MW'($urandom())),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 1) == 1, MW'($urandom_range(0, 7)), $urandom());
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
